// File: rtl/aes_pkg.sv
// Shared AES-128 controller definitions: operations-unit opcodes, round count, FSM states.
package aes_pkg;

  localparam logic [2:0] AES_OP_NOP   = 3'b000;
  localparam logic [2:0] AES_OP_KEYX  = 3'b001;
  localparam logic [2:0] AES_OP_SUB   = 3'b010;
  localparam logic [2:0] AES_OP_SHIFT = 3'b011;
  localparam logic [2:0] AES_OP_MIX   = 3'b100;
  localparam logic [2:0] AES_OP_ARK   = 3'b101;

  localparam logic [3:0] AES_NUM_ROUNDS = 4'd10;

  typedef enum logic [2:0] {
    AES_IDLE,
    AES_INIT_ARK,
    AES_KEYX,
    AES_SUB,
    AES_SHIFT,
    AES_MIX,
    AES_ARK,
    AES_DONE
  } aes_ctrl_state_t;

endpackage

// File: rtl/aes_round_controller.sv
// AES-128 round sequencer driving the combinational operations unit one step per cycle.
// Define AES_BACK_TO_BACK_EN to accept a new job in the DONE cycle.
module aes_round_controller
  import aes_pkg::*;
#(
  parameter int unsigned regSize = 32,
  parameter int unsigned vecSize = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [vecSize-1:0][regSize-1:0] plaintext,
  input  logic [vecSize-1:0][regSize-1:0] cipher_key,
  output logic                            busy,
  output logic                            done,
  output logic [vecSize-1:0][regSize-1:0] ciphertext,
  output logic [2:0]                      aes_op_select,
  output logic [vecSize-1:0][regSize-1:0] aes_operand1,
  output logic [vecSize-1:0][regSize-1:0] aes_operand2,
  input  logic [vecSize-1:0][regSize-1:0] aes_result
);

  typedef logic [vecSize-1:0][regSize-1:0] vec_t;

  aes_ctrl_state_t fsm_q, fsm_d;
  vec_t            state_q, state_d;
  vec_t            key_q, key_d;
  vec_t            ct_q, ct_d;
  logic [3:0]      round_q, round_d;
  // Low for the first edge after reset release so a coincident start is ignored.
  logic            armed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= AES_IDLE;
      state_q <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      round_q <= '0;
      armed_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      round_q <= round_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    fsm_d         = fsm_q;
    state_d       = state_q;
    key_d         = key_q;
    ct_d          = ct_q;
    round_d       = round_q;
    aes_op_select = AES_OP_NOP;
    aes_operand1  = '0;
    aes_operand2  = '0;
    busy          = 1'b1;
    done          = 1'b0;

    case (fsm_q)
      AES_IDLE: begin
        busy = 1'b0;
        if (start && armed_q) begin
          state_d = plaintext;
          key_d   = cipher_key;
          round_d = 4'd1;
          fsm_d   = AES_INIT_ARK;
        end
      end
      AES_INIT_ARK: begin
        aes_op_select = AES_OP_ARK;
        aes_operand1  = state_q;
        aes_operand2  = key_q;
        state_d       = aes_result;
        fsm_d         = AES_KEYX;
      end
      AES_KEYX: begin
        aes_op_select   = AES_OP_KEYX;
        aes_operand1    = key_q;
        aes_operand2[0] = regSize'(round_q);
        key_d           = aes_result;
        fsm_d           = AES_SUB;
      end
      AES_SUB: begin
        aes_op_select = AES_OP_SUB;
        aes_operand1  = state_q;
        state_d       = aes_result;
        fsm_d         = AES_SHIFT;
      end
      AES_SHIFT: begin
        aes_op_select = AES_OP_SHIFT;
        aes_operand1  = state_q;
        state_d       = aes_result;
        fsm_d         = (round_q < AES_NUM_ROUNDS) ? AES_MIX : AES_ARK;
      end
      AES_MIX: begin
        aes_op_select = AES_OP_MIX;
        aes_operand1  = state_q;
        state_d       = aes_result;
        fsm_d         = AES_ARK;
      end
      AES_ARK: begin
        aes_op_select = AES_OP_ARK;
        aes_operand1  = state_q;
        aes_operand2  = key_q;
        state_d       = aes_result;
        if (round_q == AES_NUM_ROUNDS) begin
          ct_d  = aes_result;
          fsm_d = AES_DONE;
        end else begin
          round_d = round_q + 4'd1;
          fsm_d   = AES_KEYX;
        end
      end
      AES_DONE: begin
        done  = 1'b1;
        fsm_d = AES_IDLE;
`ifdef AES_BACK_TO_BACK_EN
        if (start) begin
          state_d = plaintext;
          key_d   = cipher_key;
          round_d = 4'd1;
          fsm_d   = AES_INIT_ARK;
        end
`endif
      end
    endcase
  end

  assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_round_controller.sv
// Scoreboard bench for aes_round_controller with a behavioural AES operations unit.
module tb_aes_round_controller;
  import aes_pkg::*;

  typedef logic [3:0][31:0] vec_t;
  typedef struct {
    vec_t        ct;
    int unsigned launch;
  } exp_t;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic       clk = 1'b0;
  logic       rst, start, busy, done;
  vec_t       plaintext, cipher_key, ciphertext, op1, op2, res;
  logic [2:0] op_sel;

  logic [7:0]  sbox [256];
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  exp_t        sb[$];

  aes_round_controller #(.regSize(32), .vecSize(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .plaintext(plaintext), .cipher_key(cipher_key),
    .busy(busy), .done(done), .ciphertext(ciphertext),
    .aes_op_select(op_sel), .aes_operand1(op1), .aes_operand2(op2),
    .aes_result(res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] x, inv;
      x   = 8'(i);
      inv = 8'h01;
      for (int j = 0; j < 254; j++) inv = gmul(inv, x);
      sbox[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  end

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Lane c = column c, row r byte at bits [31-8r -: 8].
  function automatic vec_t aes_op(input logic [2:0] op, input vec_t a, input vec_t b);
    vec_t        o;
    logic [31:0] t;
    logic [7:0]  rc, p0, p1, p2, p3;
    o = '0;
    case (op)
      3'b001: begin
        rc = 8'h01;
        for (int i = 1; i < 16 && i < int'(b[0]); i++) rc = xt(rc);
        t    = sub_word({a[3][23:0], a[3][31:24]}) ^ {rc, 24'h0};
        o[0] = a[0] ^ t;
        o[1] = a[1] ^ o[0];
        o[2] = a[2] ^ o[1];
        o[3] = a[3] ^ o[2];
      end
      3'b010: for (int c = 0; c < 4; c++) o[c] = sub_word(a[c]);
      3'b011: for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) o[c][31-8*r -: 8] = a[(c+r)%4][31-8*r -: 8];
      3'b100: for (int c = 0; c < 4; c++) begin
        p0 = a[c][31:24]; p1 = a[c][23:16]; p2 = a[c][15:8]; p3 = a[c][7:0];
        o[c] = {xt(p0) ^ xt(p1) ^ p1 ^ p2 ^ p3,
                p0 ^ xt(p1) ^ xt(p2) ^ p2 ^ p3,
                p0 ^ p1 ^ xt(p2) ^ xt(p3) ^ p3,
                xt(p0) ^ p0 ^ p1 ^ p2 ^ xt(p3)};
      end
      3'b101: o = a ^ b;
      default: o = '0;
    endcase
    return o;
  endfunction

  assign res = aes_op(op_sel, op1, op2);

  function automatic vec_t to_v(input logic [127:0] s);
    vec_t v;
    for (int i = 0; i < 4; i++) v[i] = s[127-32*i -: 32];
    return v;
  endfunction

  function automatic logic [2:0] exp_op(input int unsigned n);
    int unsigned k;
    if (n == 1) return AES_OP_ARK;
    if (n >= 2 && n <= 46) begin
      k = (n - 2) % 5;
      case (k)
        0: return AES_OP_KEYX;
        1: return AES_OP_SUB;
        2: return AES_OP_SHIFT;
        3: return AES_OP_MIX;
        default: return AES_OP_ARK;
      endcase
    end
    case (n)
      47: return AES_OP_KEYX;
      48: return AES_OP_SUB;
      49: return AES_OP_SHIFT;
      50: return AES_OP_ARK;
      default: return AES_OP_NOP;
    endcase
  endfunction

  // Completion monitor: every done must match the oldest outstanding job.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        if (sb.size() == 0) chk("spurious_done", 128'(done), 128'd0);
        else begin
          e = sb.pop_front();
          chk("ciphertext", ciphertext, e.ct);
          chk("latency", 128'(cyc - e.launch + 1), 128'd51);
        end
      end
    end
  end

  task automatic run_job(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] ct,
                         input bit chk_ops, input bit hold);
    bit seen = 0;
    plaintext  = to_v(pt);
    cipher_key = to_v(key);
    start      = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{to_v(ct), cyc});
    if (!hold) start = 1'b0;
    for (int unsigned n = 1; n <= 60 && !seen; n++) begin
      if (chk_ops && n <= 51) chk("op_sel", 128'(op_sel), 128'(exp_op(n)));
      if (chk_ops && n == 2)  chk("keyx_round1", 128'(op2), 128'd1);
      if (chk_ops && n == 47) chk("keyx_round10", 128'(op2), 128'd10);
      if (hold && n == 10) plaintext = to_v(PT_B);
      if (done) begin
        seen  = 1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("done_seen", 128'(seen), 128'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned launch_a;
    bit          seen, min_busy;
    rst = 1'b1; start = 1'b0; plaintext = '0; cipher_key = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_ct", ciphertext, 128'd0);
    chk("rst_op", 128'(op_sel), 128'd0);
    chk("rst_op1", op1, 128'd0);
    chk("rst_op2", op2, 128'd0);

    rst = 1'b0; start = 1'b1; plaintext = to_v(PT_C1); cipher_key = to_v(KEY_C1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("release_start_ignored", 128'(busy), 128'd0);
    repeat (2) @(posedge clk); #1;
    chk("release_still_idle", 128'(busy), 128'd0);

    run_job(PT_C1, KEY_C1, CT_C1, 0, 0);
    repeat (3) @(posedge clk); #1;
    chk("ct_hold", ciphertext, to_v(CT_C1));
    chk("idle_after_job", 128'(busy), 128'd0);

    run_job(PT_B, KEY_B, CT_B, 1, 0);

    run_job(PT_C1, KEY_C1, CT_C1, 0, 1);
    repeat (60) @(posedge clk); #1;
    chk("held_start_single_job", 128'(busy), 128'd0);

    plaintext = to_v(PT_B); cipher_key = to_v(KEY_B); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (24) @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_done", 128'(done), 128'd0);
    chk("midrst_ct", ciphertext, 128'd0);
    chk("midrst_op", 128'(op_sel), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_job(PT_C1, KEY_C1, CT_C1, 0, 0);

    plaintext = to_v(PT_C1); cipher_key = to_v(KEY_C1); start = 1'b1;
    @(posedge clk); #1;
    launch_a = cyc;
    sb.push_back('{to_v(CT_C1), launch_a});
    start = 1'b0;
    min_busy = 1; seen = 0;
    for (int n = 1; n <= 60 && !seen; n++) begin
      if (!busy) min_busy = 0;
      if (done) seen = 1;
      else begin @(posedge clk); #1; end
    end
    chk("b2b_a_done", 128'(seen), 128'd1);
    plaintext = to_v(PT_B); cipher_key = to_v(KEY_B); start = 1'b1;
`ifdef AES_BACK_TO_BACK_EN
    sb.push_back('{to_v(CT_B), cyc + 1});
`endif
    @(posedge clk); #1;
    start = 1'b0;
`ifdef AES_BACK_TO_BACK_EN
    seen = 0;
    for (int n = 1; n <= 60 && !seen; n++) begin
      if (!busy) min_busy = 0;
      if (done) seen = 1;
      else begin @(posedge clk); #1; end
    end
    chk("b2b_b_done", 128'(seen), 128'd1);
    chk("b2b_b_cycle", 128'(cyc - launch_a + 1), 128'd102);
    chk("b2b_busy_held", 128'(min_busy), 128'd1);
`else
    chk("b2b_busy_job_a", 128'(min_busy), 128'd1);
    chk("no_b2b_idle", 128'(busy), 128'd0);
    repeat (60) @(posedge clk); #1;
    chk("no_b2b_still_idle", 128'(busy), 128'd0);
`endif
    repeat (3) @(posedge clk); #1;
    chk("sb_drained", 128'(sb.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
